tmr_ctrl: RTL and testbench

//   Bus-mapped millisecond timer controller for the RISC5 I/O space. Derives
//   a 1 ms tick from clk via prescaler, keeps a 32-bit ms count, compares it

---
 rtl/tmr_ctrl.sv | 142 ++++++++++++++
 tb/tb_tmr_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_ctrl.sv
// tmr_ctrl: bus-mapped millisecond timer for the RISC5 I/O space.
//   A 16-bit prescaler divides clk down to a 1 ms tick. Each tick advances a
//   32-bit ms counter. When a tick takes the counter onto the alarm value,
//   PEND is set, and irq (PEND & IE, registered) is raised until software
//   clears PEND.
//
// Optional feature: define TMR_PERIODIC_EN to implement the PER control bit
// and the PERIOD register. With PER=1, every match reloads CMP with
// CMP + PERIOD. Without the macro, PER reads 0 and PERIOD reads 0, and
// writes to either are ignored.
//
// Register map (addr):
//   0 CNT     R/W  ms count
//   1 CMP     R/W  alarm value
//   2 CTRL    bit0 RUN, bit1 IE, bit2 PER, bit3 PEND (write 1 clears)
//   3 PERIOD  R/W  periodic reload step
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   stb   bus strobe, one cycle per access
//   we    1 = write, 0 = read (sampled with stb)
//   addr  register select
//   din   write data
//   dout  read data, valid while ack=1
//   ack   access complete, one cycle after stb
//   irq   level interrupt request
module tmr_ctrl #(
  parameter int DIV = 25000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        ack,
  output logic        irq
);

  localparam logic [15:0] PRESC_TOP = 16'(DIV - 1);

  logic [15:0] presc;
  logic [31:0] cnt;
  logic [31:0] cmp;
  logic        run;
  logic        ie;
  logic        pend;
  logic        per;
  logic [31:0] period;

  logic        tick;
  logic        wr_cnt;
  logic        wr_cmp;
  logic        wr_ctrl;
  logic        match;
  logic [31:0] cnt_inc;
  logic [31:0] rdata;

  assign tick    = run && (presc == PRESC_TOP);
  assign wr_cnt  = stb && we && (addr == 2'd0);
  assign wr_cmp  = stb && we && (addr == 2'd1);
  assign wr_ctrl = stb && we && (addr == 2'd2);
  assign cnt_inc = cnt + 32'd1;
  // A CNT write in the same cycle suppresses the compare entirely.
  assign match   = tick && !wr_cnt && (cnt_inc == cmp);

  always_comb begin
    rdata = 32'd0;
    case (addr)
      2'd0:    rdata = cnt;
      2'd1:    rdata = cmp;
      2'd2:    rdata = {28'd0, pend, per, ie, run};
      default: rdata = period;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= 16'd0;
      cnt   <= 32'd0;
      cmp   <= 32'hFFFF_FFFF;
      run   <= 1'b0;
      ie    <= 1'b0;
      pend  <= 1'b0;
      ack   <= 1'b0;
      dout  <= 32'd0;
      irq   <= 1'b0;
    end else begin
      ack  <= stb;
      dout <= stb ? rdata : 32'd0;
      // irq follows PEND/IE with one cycle of lag.
      irq  <= pend && ie;

      if (wr_cnt) begin
        cnt   <= din;
        presc <= 16'd0;
      end else begin
        if (tick) cnt <= cnt_inc;
        if (run)  presc <= tick ? 16'd0 : presc + 16'd1;
      end

      if (wr_cmp) begin
        cmp <= din;
      end
`ifdef TMR_PERIODIC_EN
      else if (match && per) begin
        cmp <= cmp + period;
      end
`endif

      if (wr_ctrl) begin
        run <= din[0];
        ie  <= din[1];
      end

      // A match sets PEND even if software clears it in the same cycle.
      if (match) begin
        pend <= 1'b1;
      end else if (wr_ctrl && din[3]) begin
        pend <= 1'b0;
      end
    end
  end

`ifdef TMR_PERIODIC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      per    <= 1'b0;
      period <= 32'd0;
    end else begin
      if (wr_ctrl) per <= din[2];
      if (stb && we && (addr == 2'd3)) period <= din;
    end
  end
`else
  assign per    = 1'b0;
  assign period = 32'd0;
`endif

endmodule

// File: tb/tb_tmr_ctrl.sv
// tb_tmr_ctrl: directed bench for tmr_ctrl with DIV=4. A cycle-level model
// of the register file runs alongside the DUT, and a compare process checks
// ack, read data and irq every cycle. Directed scenarios add literal checks.
module tb_tmr_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        ack;
  logic        irq;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  tmr_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr),
    .din(din), .dout(dout), .ack(ack), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: registers, elapsed run cycles since the last prescaler
  // restart, and the outputs that must appear after each edge.
  logic [31:0] m_cnt, m_cmp, m_period, m_dout;
  logic        m_run, m_ie, m_per, m_pend, m_ack, m_rd, m_irq;
  int          m_ph;

  always @(posedge clk) begin : model
    logic        tk, mt, wcnt, wcmp, wctl;
    logic [31:0] rv;
    if (rst) begin
      m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_period = 0; m_dout = 0;
      m_run = 0; m_ie = 0; m_per = 0; m_pend = 0;
      m_ack = 0; m_rd = 0; m_irq = 0; m_ph = 0;
    end else begin
      case (addr)
        2'd0:    rv = m_cnt;
        2'd1:    rv = m_cmp;
        2'd2:    rv = {28'd0, m_pend, m_per, m_ie, m_run};
        default: rv = m_period;
      endcase
      m_ack  = stb;
      m_rd   = stb && !we;
      m_dout = rv;
      m_irq  = m_pend && m_ie;
      wcnt = stb && we && addr == 2'd0;
      wcmp = stb && we && addr == 2'd1;
      wctl = stb && we && addr == 2'd2;
      // Every DIV-th running cycle is a millisecond tick.
      tk = m_run && (m_ph % DIV == DIV - 1);
      mt = tk && !wcnt && (m_cnt + 32'd1 == m_cmp);
      if (wcnt) begin
        m_cnt = din;
        m_ph  = 0;
      end else begin
        if (tk)    m_cnt = m_cnt + 32'd1;
        if (m_run) m_ph  = m_ph + 1;
      end
      if (wcmp) m_cmp = din;
      else if (mt && m_per) m_cmp = m_cmp + m_period;
      if (mt) m_pend = 1'b1;
      else if (wctl && din[3]) m_pend = 1'b0;
      if (wctl) begin
        m_run = din[0];
        m_ie  = din[1];
`ifdef TMR_PERIODIC_EN
        m_per = din[2];
`endif
      end
`ifdef TMR_PERIODIC_EN
      if (stb && we && addr == 2'd3) m_period = din;
`endif
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ack", {31'd0, ack}, {31'd0, m_ack});
      if (m_ack && m_rd) chk("dout", dout, m_dout);
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  // All tasks start and end #1 after a rising edge.
  task automatic acc(input logic w, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] r, output logic k);
    stb = 1'b1; we = w; addr = a; din = d;
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
    r = dout; k = ack;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic k;
    acc(1'b1, a, d, r, k);
    chk("wr_ack", {31'd0, k}, 32'd1);
  endtask

  task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] e);
    logic [31:0] r;
    logic k;
    acc(1'b0, a, 32'd0, r, k);
    chk({nm, "_ack"}, {31'd0, k}, 32'd1);
    chk(nm, r, e);
  endtask

  task automatic waitc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 2'd0; din = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    rd("rst_cnt", 2'd0, 32'd0);
    rd("rst_cmp", 2'd1, 32'hFFFF_FFFF);
    rd("rst_ctrl", 2'd2, 32'd0);
    rd("rst_period", 2'd3, 32'd0);

    // Free run: 40 clocks give 10 ticks
    do_reset();
    wr(2'd2, 32'h1);
    waitc(40);
    rd("run_cnt", 2'd0, 32'd10);
    rd("run_ctrl", 2'd2, 32'h1);
    chk("run_irq", {31'd0, irq}, 32'd0);

    // Alarm at 5, irq one cycle behind PEND, clear drops irq two cycles later
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd2, 32'h3);
    waitc(20);
    chk("alm_irq_lag", {31'd0, irq}, 32'd0);
    rd("alm_ctrl", 2'd2, 32'hB);
    chk("alm_irq", {31'd0, irq}, 32'd1);
    wr(2'd2, 32'hB);
    chk("clr_irq_w1", {31'd0, irq}, 32'd1);
    waitc(1);
    chk("clr_irq_w2", {31'd0, irq}, 32'd0);

    // Writing CMP equal to CNT does not match; wrap to 0 matches CMP=0
    do_reset();
    wr(2'd1, 32'd0);
    rd("cmp_eq_ctrl", 2'd2, 32'd0);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd2, 32'h1);
    waitc(4);
    rd("wrap_cnt", 2'd0, 32'd0);
    rd("wrap_ctrl", 2'd2, 32'h9);

    // CNT write in a tick cycle wins and restarts the prescaler
    do_reset();
    wr(2'd2, 32'h1);
    waitc(7);
    wr(2'd0, 32'd100);
    rd("ld_cnt", 2'd0, 32'd100);
    waitc(2);
    rd("ld_cnt_hold", 2'd0, 32'd100);
    rd("ld_cnt_tick", 2'd0, 32'd101);

    // PEND clear coinciding with a match: set wins
    do_reset();
    wr(2'd1, 32'd1);
    wr(2'd2, 32'h3);
    waitc(4);
    wr(2'd1, 32'd2);
    waitc(2);
    wr(2'd2, 32'hB);
    chk("race_irq1", {31'd0, irq}, 32'd1);
    rd("race_ctrl", 2'd2, 32'hB);
    chk("race_irq2", {31'd0, irq}, 32'd1);

    // Reset during an access drops it
    stb = 1'b1; we = 1'b0; addr = 2'd1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; stb = 1'b0;
    chk("rstacc_ack", {31'd0, ack}, 32'd0);
    chk("rstacc_dout", dout, 32'd0);

`ifdef TMR_PERIODIC_EN
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd3, 32'd3);
    wr(2'd2, 32'h7);
    waitc(12);
    rd("per_cmp1", 2'd1, 32'd6);
    rd("per_ctrl1", 2'd2, 32'hF);
    wr(2'd2, 32'hF);
    rd("per_clr", 2'd2, 32'h7);
    waitc(8);
    rd("per_ctrl2", 2'd2, 32'hF);
    rd("per_cnt2", 2'd0, 32'd6);
    rd("per_cmp2", 2'd1, 32'd9);
`else
    do_reset();
    wr(2'd3, 32'd7);
    rd("noper_period", 2'd3, 32'd0);
    wr(2'd2, 32'h4);
    rd("noper_ctrl", 2'd2, 32'd0);
`endif

    waitc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
